// File: rtl/padctrl_reg_pkg.sv
// Pad register-file dimensions shared by padctrl blocks.
package padctrl_reg_pkg;

  localparam int unsigned NMioPads = 16;
  localparam int unsigned NDioPads = 4;
  localparam int unsigned AttrDw   = 8;

endpackage : padctrl_reg_pkg

// File: rtl/padctrl_seq_pkg.sv
// Types and constants for the pad attribute update sequencer.
package padctrl_seq_pkg;

  import padctrl_reg_pkg::*;

  // Unified pad index space: MIO pads first, then DIO pads.
  localparam int unsigned NPads   = NMioPads + NDioPads;
  localparam int unsigned PadIdxW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SETTLE = 2'd2
  } seq_state_e;

endpackage : padctrl_seq_pkg

// File: rtl/padctrl_settle_cnt.sv
// Loadable down-counter used to time the settle window after a pad update.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   load_i         load load_val_i (takes priority over dec_i)
//   load_val_i     value to load
//   dec_i          decrement by one; saturates at zero
//   zero_c_o       combinational flag, counter equals zero
module padctrl_settle_cnt #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_c_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c_o = (cnt_q == '0);

endmodule : padctrl_settle_cnt

// File: rtl/padctrl_attr_seq.sv
// Applies requested MIO/DIO pad attributes one pad at a time, visiting pads
// with a round-robin pointer and waiting a settle window after each update.
// Optional feature macro: PADCTRL_SEQ_LOCK_EN adds lock_i, which freezes the
// applied attributes (no new update starts; a running settle completes).
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   lock_i         (PADCTRL_SEQ_LOCK_EN only) freeze updates
//   mio_attr_i     requested MIO attributes, NMioPads*AttrDw
//   dio_attr_i     requested DIO attributes, NDioPads*AttrDw
//   mio_attr_o     applied MIO attributes (registered)
//   dio_attr_o     applied DIO attributes (registered)
//   upd_valid_o    one-cycle pulse, a pad was updated (registered)
//   upd_idx_o      index of the updated pad, MIO 0..15, DIO 16..19 (registered)
//   busy_o         sequencer not idle, decoded from the state register
module padctrl_attr_seq
  import padctrl_reg_pkg::*;
  import padctrl_seq_pkg::*;
#(
  parameter int unsigned SettleCycles = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
`ifdef PADCTRL_SEQ_LOCK_EN
  input  logic                       lock_i,
`endif
  input  logic [NMioPads*AttrDw-1:0] mio_attr_i,
  input  logic [NDioPads*AttrDw-1:0] dio_attr_i,
  output logic [NMioPads*AttrDw-1:0] mio_attr_o,
  output logic [NDioPads*AttrDw-1:0] dio_attr_o,
  output logic                       upd_valid_o,
  output logic [PadIdxW-1:0]         upd_idx_o,
  output logic                       busy_o
);

  localparam int unsigned CntW  = $clog2(SettleCycles + 1);
  localparam int unsigned MioW  = NMioPads * AttrDw;
  localparam int unsigned AllW  = NPads * AttrDw;

  // A zero-length settle window would let updates fire back to back.
  if (SettleCycles < 1) begin : g_bad_settle
    $error("padctrl_attr_seq: SettleCycles must be >= 1");
  end

  seq_state_e         state_q, state_d;
  logic [PadIdxW-1:0] ptr_q, ptr_d;
  logic [AllW-1:0]    applied_q, applied_d;
  logic               upd_valid_q, upd_valid_d;
  logic [PadIdxW-1:0] upd_idx_q, upd_idx_d;

  logic [AllW-1:0]    req_all;
  logic [NPads-1:0]   diff;
  logic               any_diff;
  logic [PadIdxW-1:0] ptr_next;
  logic               lock;
  logic               cnt_load, cnt_dec, cnt_zero;

`ifdef PADCTRL_SEQ_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  // MIO occupies the low lanes so the pad index maps directly to the lane.
  assign req_all = {dio_attr_i, mio_attr_i};

  // Per-pad pending flag on the live request.
  always_comb begin
    diff = '0;
    for (int unsigned i = 0; i < NPads; i++) begin
      diff[i] = (req_all[i*AttrDw +: AttrDw] != applied_q[i*AttrDw +: AttrDw]);
    end
  end

  assign any_diff = |diff;
  assign ptr_next = (ptr_q == PadIdxW'(NPads - 1)) ? '0 : ptr_q + PadIdxW'(1);

  // Next state, pointer, applied attributes and update strobe.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    applied_d   = applied_q;
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_diff && !lock) begin
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (lock || !any_diff) begin
          // Nothing left to apply (or frozen): park without touching ptr.
          state_d = IDLE;
        end else if (diff[ptr_q]) begin
          applied_d[int'(ptr_q)*AttrDw +: AttrDw] = req_all[int'(ptr_q)*AttrDw +: AttrDw];
          upd_valid_d = 1'b1;
          upd_idx_d   = ptr_q;
          cnt_load    = 1'b1;
          state_d     = SETTLE;
        end else begin
          ptr_d = ptr_next;
        end
      end

      SETTLE: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          // Move past the pad just updated so other pads get a fair turn.
          ptr_d   = ptr_next;
          state_d = (any_diff && !lock) ? SCAN : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      applied_q   <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      applied_q   <= applied_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
    end
  end

  // Loaded with SettleCycles-1 so SETTLE lasts exactly SettleCycles cycles.
  padctrl_settle_cnt #(
    .CntW (CntW)
  ) u_settle_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (CntW'(SettleCycles - 1)),
    .dec_i      (cnt_dec),
    .zero_c_o   (cnt_zero)
  );

  assign mio_attr_o  = applied_q[MioW-1:0];
  assign dio_attr_o  = applied_q[AllW-1:MioW];
  assign upd_valid_o = upd_valid_q;
  assign upd_idx_o   = upd_idx_q;
  assign busy_o      = (state_q != IDLE);

endmodule : padctrl_attr_seq
